// File: rtl/alu_slice_sequencer_if.sv
// alu_slice_sequencer_if: request and response channels between issue logic and the slice sequencer
interface alu_slice_sequencer_if #(parameter int WIDTH = 4);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_binv;
    logic             req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_zero;
    logic             rsp_error;
    modport master (
        output req_valid, req_op, req_a, req_b, req_binv, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_error
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_binv, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_error
    );
endinterface

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: runs a 1-bit ALU slice once per bit, LSB first, chaining carry and assembling the result
module alu_slice_sequencer #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    alu_slice_sequencer_if.slave bus,
    output logic slc_reset,
    output logic slc_op1,
    output logic slc_op0,
    output logic slc_a,
    output logic slc_b,
    output logic slc_binv,
    output logic slc_cin,
    input  logic slc_y1,
    input  logic slc_y0,
    input  logic slc_zero,
    input  logic slc_error
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, ARM, RUN, RESP} state_t;
    state_t           state;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             binv;
    logic             carry;
    logic             err;
    logic             rsp_valid;
    logic             req_ready;
    logic [IW-1:0]    idx;
    logic [7:0]       tmo;
    logic             active;
    logic             done;
    assign active = (state == ARM) || (state == RUN);
    // completion is only meaningful once the slice has left reset
    assign done = (state == RUN) && (slc_y1 || slc_y0 || slc_zero || slc_error);
    // slice held in reset while our reset is low, and pulsed for one cycle per bit
    assign slc_reset = !reset || (state == ARM);
    assign slc_op1   = active && op[1];
    assign slc_op0   = active && op[0];
    assign slc_a     = active && a[idx];
    assign slc_b     = active && b[idx];
    assign slc_binv  = active && binv;
    assign slc_cin   = active && carry;
    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = result;
    assign bus.rsp_cout   = carry;
    assign bus.rsp_error  = err;
    assign bus.rsp_zero   = rsp_valid && (result == '0) && !err;
    // sequencer FSM: accept, pulse slice reset, wait for completion per bit, then respond
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op        <= '0;
            a         <= '0;
            b         <= '0;
            binv      <= 1'b0;
            carry     <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            idx       <= '0;
            tmo       <= '0;
            rsp_valid <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready) begin
                        op        <= bus.req_op;
                        a         <= bus.req_a;
                        b         <= bus.req_b;
                        binv      <= bus.req_binv;
                        carry     <= bus.req_cin;
                        err       <= 1'b0;
                        result    <= '0;
                        idx       <= '0;
                        req_ready <= 1'b0;
                        state     <= ARM;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ARM: begin
                    tmo   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (done) begin
                        if (slc_error) begin
                            err   <= 1'b1;
                            state <= RESP;
                        end else begin
                            result[idx] <= slc_y0;
                            carry       <= slc_y1;
                            if (idx == IW'(WIDTH - 1)) begin
                                state <= RESP;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= ARM;
                            end
                        end
                    end else if (tmo == 8'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= RESP;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_valid && bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb_alu_slice_sequencer: random and directed requests against a bench slice model and a behavioural reference
module tb_alu_slice_sequencer;
    localparam int W  = 4;
    localparam int TO = 15;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    alu_slice_sequencer_if #(.WIDTH(W)) bus();
    logic slc_reset, slc_op1, slc_op0, slc_a, slc_b, slc_binv, slc_cin;
    logic slc_y1, slc_y0, slc_zero, slc_error;
    alu_slice_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .slc_reset(slc_reset), .slc_op1(slc_op1), .slc_op0(slc_op0),
        .slc_a(slc_a), .slc_b(slc_b), .slc_binv(slc_binv), .slc_cin(slc_cin),
        .slc_y1(slc_y1), .slc_y0(slc_y0), .slc_zero(slc_zero), .slc_error(slc_error)
    );
    typedef struct {
        logic [W-1:0] result;
        logic         cout;
        logic         zero;
        logic         error;
        int           lat;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t last;
    logic cin_log[$];
    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0, pulses = 0, base = 0, cbase = 0, cnt = 0;
    int n_tab[W];
    int err_bit = 99;
    int bit_i;
    logic act, is_err, fb, prev_v = 1'b0;

    task automatic check(input string name, input longint act_v, input longint exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act_v, exp_v, cyc);
        end
    endtask

    // reference: whole-word addition truncated at the erroring bit, latency as per-bit step sums
    function automatic rsp_t predict(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic binv, input logic cin, input int eb);
        rsp_t r;
        int bb, k, m, low;
        bb = int'(binv ? ~b : b);
        if (op == 2'b10) begin
            r.result = '0;
            r.cout   = cin;
            r.error  = 1'b1;
            r.lat    = TO + 2;
        end else begin
            k = (eb < W) ? eb : W;
            m = (1 << k) - 1;
            low = (int'(a) & m) + (bb & m) + int'(cin);
            r.result = W'(low & m);
            r.cout   = ((low >> k) & 1) != 0;
            r.error  = k < W;
            r.lat    = 1;
            for (int i = 0; i < W && i <= k; i++) r.lat += n_tab[i] + 2;
        end
        r.zero = (r.result == '0) && !r.error;
        return r;
    endfunction

    function automatic logic [W-1:0] cin_bits();
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++) if (cbase + i < cin_log.size()) v[i] = cin_log[cbase + i];
        return v;
    endfunction

    // cycle counter, accept timestamp, slice step counter and slice reset pulse count
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid && bus.req_ready) acc_cyc <= cyc + 1;
        cnt <= slc_reset ? 0 : cnt + 1;
        if (slc_reset && reset) pulses <= pulses + 1;
    end

    // slice model: full adder result or error appears n cycles after reset falls; op 10 never completes
    always_comb begin
        bit_i  = pulses - base - 1;
        act    = reset && !slc_reset && !(slc_op1 && !slc_op0) && bit_i >= 0 && bit_i < W
                 && cnt >= n_tab[(bit_i >= 0 && bit_i < W) ? bit_i : 0];
        is_err = act && (bit_i == err_bit);
        fb     = slc_b ^ slc_binv;
        slc_error = is_err;
        slc_y0    = act && !is_err && (slc_a ^ fb ^ slc_cin);
        slc_y1    = act && !is_err && ((slc_a & fb) | (slc_a & slc_cin) | (fb & slc_cin));
        slc_zero  = act && !is_err && !slc_y0 && !slc_y1;
    end

    // compare process: log carry-in per slice pulse and check every response cycle against the reference
    always @(negedge clk) begin
        if (reset && slc_reset) cin_log.push_back(slc_cin);
        if (!reset) prev_v = 1'b0;
        else if (exp_q.size() == 0) check("no_rsp", bus.rsp_valid, 0);
        else if (bus.rsp_valid) begin
            if (!prev_v) begin
                check("latency", cyc - acc_cyc, exp_q[0].lat);
                last.lat = cyc - acc_cyc;
            end
            check("result", bus.rsp_result, exp_q[0].result);
            check("cout", bus.rsp_cout, exp_q[0].cout);
            check("zero", bus.rsp_zero, exp_q[0].zero);
            check("error", bus.rsp_error, exp_q[0].error);
            check("req_ready_blocked", bus.req_ready, 0);
            prev_v = 1'b1;
            if (bus.rsp_ready) begin
                last.result = bus.rsp_result;
                last.cout   = bus.rsp_cout;
                last.zero   = bus.rsp_zero;
                last.error  = bus.rsp_error;
                void'(exp_q.pop_front());
                prev_v = 1'b0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic binv, input logic cin, input int eb, input int nlo, input int nhi);
        bit ok = 0;
        for (int i = 0; i < W; i++) n_tab[i] = $urandom_range(nhi, nlo);
        err_bit = eb;
        base    = pulses;
        cbase   = cin_log.size();
        exp_q.push_back(predict(op, a, b, binv, cin, eb));
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_binv  = binv;
        bus.req_cin   = cin;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_rsp();
        bit hs = 0, ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (hs) begin ok = 1; break; end
            bus.rsp_ready = bus.rsp_valid && ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs = bus.rsp_valid && bus.rsp_ready;
        end
        bus.rsp_ready = 1'b0;
        if (!ok) check("rsp_timeout", 0, 1);
    endtask

    initial begin
        int p0;
        bit seen;
        bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0;
        bus.req_binv = 0; bus.req_cin = 0; bus.rsp_ready = 0;
        for (int i = 0; i < W; i++) n_tab[i] = 0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_slc_reset", slc_reset, 1);
        check("rst_outs", {slc_op1, slc_op0, slc_a, slc_b, slc_binv, slc_cin,
                           bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_error}, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rel_slc_reset", slc_reset, 0);
        @(negedge clk);
        check("rel_req_ready", bus.req_ready, 1);

        issue(2'b00, 4'b0011, 4'b0001, 0, 0, 99, 4, 4);
        wait_rsp();
        check("t1_result", last.result, 4'b0100);
        check("t1_cout", last.cout, 0);
        check("t1_zero", last.zero, 0);
        check("t1_error", last.error, 0);
        check("t1_latency", last.lat, 25);
        check("t1_cin_seq", cin_bits(), 4'b0110);
        check("t1_pulses", pulses - base, 4);

        issue(2'b00, 4'b1111, 4'b0001, 0, 0, 99, 4, 4);
        wait_rsp();
        check("t2_result", last.result, 4'b0000);
        check("t2_cout", last.cout, 1);
        check("t2_zero", last.zero, 1);
        check("t2_cin_seq", cin_bits(), 4'b1110);

        issue(2'b01, 4'b0110, 4'b0011, 0, 0, 2, 2, 2);
        wait_rsp();
        check("t3_error", last.error, 1);
        check("t3_result", last.result, 4'b0001);
        check("t3_zero", last.zero, 0);
        check("t3_pulses", pulses - base, 3);

        issue(2'b10, 4'b1010, 4'b0101, 0, 1, 99, 1, 1);
        wait_rsp();
        check("t4_error", last.error, 1);
        check("t4_result", last.result, 0);
        check("t4_latency", last.lat, TO + 2);
        check("t4_pulses", pulses - base, 1);

        issue(2'b00, 4'b0101, 4'b0110, 1, 1, 99, 0, 3);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = bus.rsp_valid; end
        check("t5_rsp_seen", seen, 1);
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b1;
            bus.req_a = 4'b1111;
            @(negedge clk);
            check("t5_req_blocked", bus.req_ready, 0);
        end
        @(posedge clk); #1 bus.req_valid = 1'b0;
        check("t5_no_accept", pulses - p0, 0);
        wait_rsp();
        @(negedge clk);
        check("t5_ready_after", bus.req_ready, 1);

        issue(2'b00, 4'b1001, 4'b0111, 0, 0, 99, 4, 4);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); seen = (pulses - base) == 2; end
        check("t6_reach_bit1", seen, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rsp_valid", bus.rsp_valid, 0);
        check("t6_req_ready", bus.req_ready, 0);
        check("t6_slc_reset", slc_reset, 1);
        check("t6_outs", {slc_op1, slc_op0, slc_a, slc_b, slc_binv, slc_cin,
                          bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_error}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (40) @(posedge clk);
        issue(2'b00, 4'b1001, 4'b0111, 0, 0, 99, 1, 3);
        wait_rsp();

        for (int t = 0; t < 60; t++) begin
            issue(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, W - 1) : 99, 0, 5);
            wait_rsp();
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end
endmodule

// File: doc/alu_slice_sequencer.md
# alu_slice_sequencer

Controller that performs a WIDTH-bit operation by running the 1-bit bit-serial ALU slice once per bit position, LSB first. It accepts one request over a valid/ready handshake and drives the slice's control and operand inputs. Each slice run is restarted with a slice reset pulse. The block detects slice completion, chains the carry (Y1) into the next bit's Cin and returns the assembled result over a valid/ready response channel. It sits between the datapath issue logic and a single instance of the slice FSM.

## Interface
- WIDTH, 4: operand/result width; number of slice runs per request (2..16).
- TIMEOUT, 15: max RUN cycles per bit before the request is aborted with error (4..255).

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  {Op1,Op0} forwarded to slice.
- req_a, req_b  in  WIDTH  operands.
- req_binv  in  1  B-invert, same for every bit.
- req_cin  in  1  carry-in to bit 0.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_result  out  WIDTH  captured Y0 per bit.
- rsp_cout  out  1  Y1 of last completed bit.
- rsp_zero  out  1  rsp_result == 0 and no error.
- rsp_error  out  1  slice Error seen or timeout.
- slc_reset  out  1  active-high reset to slice.
- slc_op1, slc_op0, slc_a, slc_b, slc_binv, slc_cin  out  1 each  slice inputs.
- slc_y1, slc_y0, slc_zero, slc_error  in  1 each  slice outputs (combinational from slice state).

## Operation
- States: IDLE, ARM, RUN, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op, a, b, binv, cin; set idx=0, carry=req_cin, err=0, result=0. Then go to ARM.
- ARM (1 cycle): slc_reset=1, tmo=0. Next state is RUN.
- Slice drive in ARM/RUN, held constant for the whole bit step:
  - slc_op1/op0 = op.
  - slc_a = a[idx], slc_b = b[idx], slc_binv = binv.
  - slc_cin = carry (bit 0: latched req_cin).
- Slice drive in IDLE/RESP: all slice inputs 0, slc_reset=0.
- RUN: done = slc_y1|slc_y0|slc_zero|slc_error. Done is evaluated only in RUN; it is masked in ARM.
  - done && slc_error: err=1, go to RESP. result bits for idx and above stay 0.
  - done && !slc_error:
    - result[idx]=slc_y0, carry=slc_y1.
    - If idx==WIDTH-1, go to RESP; otherwise idx++ and go to ARM.
  - !done: tmo++. If tmo==TIMEOUT-1, set err=1 and go to RESP. This covers an Op=10 slice loop and slice hang states.
- RESP: rsp_valid=1. All rsp_* are stable until rsp_valid&&rsp_ready, then go to IDLE.
- rsp_cout = carry. It equals req_cin if no bit completed.
- rsp_zero = (result==0) & !err.
- New requests are blocked (req_ready=0) from acceptance until the cycle after the response handshake.

## Timing
- Reset low (async):
  - state=IDLE; all registers cleared.
  - rsp_valid=0, req_ready=0 while reset is low; req_ready=1 from the first clk after release.
  - slc_reset=1 combinationally while reset is low.
  - All other outputs 0.
- Reset mid-operation: request is abandoned, no response is issued, slice is held in reset.
- Per bit: 1 ARM cycle + (n+1) RUN cycles, where n = slice transitions from S0 to its output state. The first RUN cycle always sees the slice in S0 with all outputs 0.
- Request latency, accept edge to rsp_valid: sum over bits of (n_i+2) + 1 cycle.
- rsp_valid is registered; it rises the cycle after the final capture.
- Back-to-back: minimum 1 IDLE cycle between responses.
- Timeout: error is flagged at the TIMEOUT-th RUN cycle without done. rsp_valid rises on the next cycle.

## Test plan
Each scenario uses a bench slice model that raises a programmed {y1,y0} or error n cycles after slc_reset falls.
- WIDTH=4, model returns y0=a^b^cin, y1=maj after n=4 each, A=0011, B=0001, cin=0, binv=0:
  - Required: rsp_result=0100, cout=0, zero=0, error=0.
  - Required: rsp_valid exactly 4*6+1=25 cycles after accept.
  - Required: slc_cin observed per bit = 0,1,1,0.
- Same model, A=1111, B=0001: rsp_result=0000, cout=1, zero=1; each bit's slc_cin equals the previous y1.
- Model raises slc_error on bit 2:
  - Required: rsp_error=1, result[3:2]=00, zero=0.
  - Required: exactly 3 slc_reset pulses observed.
- Model never completes (Op=10): error after TIMEOUT RUN cycles on bit 0; result=0; only one slc_reset pulse.
- rsp_ready held low 10 cycles:
  - Required: rsp_* stable, req_ready=0, a second req_valid is not accepted.
  - After the handshake: IDLE, req_ready=1 next cycle.
- reset driven low during RUN of bit 1: outputs are immediately 0, slc_reset=1, no rsp_valid after release; the next request completes normally.
